// File: rtl/mac_drain.sv
// Drains the FP16 MAC accumulator: counts products per kernel window, captures the sum
// (optional ReLU) into a small FWFT FIFO, and pulses an accumulator clear.
module mac_drain #(
  parameter int KERNEL_SIZE = 9,
  parameter int FIFO_DEPTH  = 4,
  parameter int RELU_EN     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] mac_out,
  input  logic        in_valid,
  output logic        stall,
  output logic        acc_clear,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        err
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {ACCUM, SETTLE, CAPTURE} state_t;

  state_t          state_q, state_d;
  logic [9:0]      prod_cnt_q, prod_cnt_d;
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   occ_q, occ_d;
  logic            stall_q, stall_d;
  logic            acc_clear_q, acc_clear_d;
  logic            out_valid_q, out_valid_d;
  logic            err_q, err_d;
  logic [15:0]     mem_q [FIFO_DEPTH];
  logic            accept, push, pop, fifo_full;
  logic [15:0]     result;

  assign accept    = in_valid && !stall_q;
  assign fifo_full = (occ_q == CW'(FIFO_DEPTH));
  assign push      = (state_q == CAPTURE) && !fifo_full;
  assign pop       = out_valid_q && out_ready;
  // ReLU only inspects the sign bit, so -0 also collapses to +0
  assign result    = ((RELU_EN != 0) && mac_out[15]) ? 16'h0000 : mac_out;

  always_comb begin
    state_d    = state_q;
    prod_cnt_d = prod_cnt_q;
    case (state_q)
      ACCUM: begin
        if (accept) begin
          if (prod_cnt_q == 10'(KERNEL_SIZE - 1)) begin
            prod_cnt_d = '0;
            state_d    = SETTLE;
          end else begin
            prod_cnt_d = prod_cnt_q + 10'd1;
          end
        end
      end
      SETTLE:  state_d = CAPTURE;
      CAPTURE: if (push) state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
    occ_d       = occ_q + CW'(push) - CW'(pop);
    stall_d     = (state_d != ACCUM);
    // Clear is registered, so predict next cycle's push from next-state occupancy
    acc_clear_d = (state_d == CAPTURE) && (occ_d != CW'(FIFO_DEPTH));
    out_valid_d = (occ_d != '0);
    err_d       = err_q || (in_valid && stall_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ACCUM;
      prod_cnt_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      stall_q     <= 1'b0;
      acc_clear_q <= 1'b0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      prod_cnt_q  <= prod_cnt_d;
      occ_q       <= occ_d;
      stall_q     <= stall_d;
      acc_clear_q <= acc_clear_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 16'h0000;
    end else if (push) begin
      mem_q[wr_ptr_q] <= result;
    end
  end

  assign stall     = stall_q;
  assign acc_clear = acc_clear_q;
  assign out_valid = out_valid_q;
  assign out_data  = mem_q[rd_ptr_q];
  assign err       = err_q;

endmodule
